// File: rtl/cb_baud_gen_mc_pkg.sv
// -----------------------------------------------------------------------------
// cb_baud_pkg
// Shared definitions for the multi-channel fractional baud generator.
//   ch_mode_e    : per-cycle action a channel takes (off / sync / tick / run)
//   phase_width  : width of the oversample phase index for a given OSR
//   div_clamp    : integer divisor with 0 treated as 1
// -----------------------------------------------------------------------------
package cb_baud_pkg;

   typedef enum logic [1:0] {
      CH_OFF  = 2'd0,   // channel disabled: state parked at zero
      CH_SYNC = 2'd1,   // restart to mid-bit
      CH_TICK = 2'd2,   // terminal count reached: emit os_tick
      CH_RUN  = 2'd3    // counting inside a period
   } ch_mode_e;

   function automatic int unsigned phase_width(input int unsigned osr);
      if (osr < 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(osr);
      end
   endfunction

   function automatic logic [31:0] div_clamp(input logic [31:0] div);
      if (div == 32'd0) begin
         return 32'd1;
      end else begin
         return div;
      end
   endfunction

endpackage

// File: rtl/cb_baud_gen_mc_if.sv
// -----------------------------------------------------------------------------
// cb_baud_gen_mc_if
// Control/status bundle of the baud generator, all vectors packed per channel.
//   master : drives ch_en, cfg_upd, div_int, div_frac, sync
//            observes cfg_pend, os_tick, bit_tick, os_phase
//   slave  : the generator side (directions reversed)
// Channel k occupies [k*DW +: DW], [k*FW +: FW], [k*OSW +: OSW] and bit k.
// -----------------------------------------------------------------------------
interface cb_baud_gen_mc_if #(
   parameter int unsigned NCH = 2,
   parameter int unsigned DW  = 16,
   parameter int unsigned FW  = 4,
   parameter int unsigned OSW = 4
);
   logic [NCH-1:0]     ch_en;
   logic [NCH-1:0]     cfg_upd;
   logic [NCH*DW-1:0]  div_int;
   logic [NCH*FW-1:0]  div_frac;
   logic [NCH-1:0]     sync;
   logic [NCH-1:0]     cfg_pend;
   logic [NCH-1:0]     os_tick;
   logic [NCH-1:0]     bit_tick;
   logic [NCH*OSW-1:0] os_phase;

   modport master (
      output ch_en, cfg_upd, div_int, div_frac, sync,
      input  cfg_pend, os_tick, bit_tick, os_phase
   );

   modport slave (
      input  ch_en, cfg_upd, div_int, div_frac, sync,
      output cfg_pend, os_tick, bit_tick, os_phase
   );
endinterface

// File: rtl/cb_baud_gen_mc_ch.sv
// -----------------------------------------------------------------------------
// cb_baud_ch
// One fractional baud channel.
//   clk_sys, rst        : system clock, async active-high reset
//   i_ch_en             : channel enable (level)
//   i_cfg_upd           : capture i_div_int/i_div_frac into the shadow
//   i_sync              : restart phase at mid-bit
//   i_div_int/i_div_frac: divisor inputs
//   o_cfg_pend          : shadow holds a divisor not yet active
//   o_os_tick/o_bit_tick: registered 1-cycle ticks
//   o_os_phase          : oversample index 0..OSR-1
// Period of the running os interval is div_int_act (0 read as 1) plus the
// carry out of acc + div_frac_act; the accumulator advances on each tick.
// -----------------------------------------------------------------------------
module cb_baud_ch
   import cb_baud_pkg::*;
#(
   parameter int unsigned DW  = 16,
   parameter int unsigned FW  = 4,
   parameter int unsigned OSR = 16,
   parameter int unsigned OSW = phase_width(OSR)
) (
   input  logic           clk_sys,
   input  logic           rst,
   input  logic           i_ch_en,
   input  logic           i_cfg_upd,
   input  logic           i_sync,
   input  logic [DW-1:0]  i_div_int,
   input  logic [FW-1:0]  i_div_frac,
   output logic           o_cfg_pend,
   output logic           o_os_tick,
   output logic           o_bit_tick,
   output logic [OSW-1:0] o_os_phase
);

   logic [DW-1:0]  r_cnt, r_int_act, r_int_sh;
   logic [FW-1:0]  r_acc, r_frac_act, r_frac_sh;
   logic [OSW-1:0] r_phase;
   logic           r_pend, r_os_tick, r_bit_tick;

   logic [DW-1:0]  w_cnt_nxt, w_int_act_nxt, w_int_sh_nxt;
   logic [FW-1:0]  w_acc_nxt, w_frac_act_nxt, w_frac_sh_nxt;
   logic [OSW-1:0] w_phase_nxt;
   logic           w_pend_nxt, w_os_nxt, w_bit_nxt;

   logic [DW-1:0]  w_int_eff;
   logic [DW-1:0]  w_last;
   logic [FW:0]    w_sum;
   logic           w_phase_wrap;
   ch_mode_e       w_mode;

   // Terminal count of the running period and the action for this cycle
   always_comb begin
      w_int_eff    = DW'(div_clamp(32'(r_int_act)));
      w_sum        = {1'b0, r_acc} + {1'b0, r_frac_act};
      // P-1 = int_eff-1+carry; cannot overflow DW because int_eff >= 1
      w_last       = w_int_eff - DW'(1'b1) + DW'(w_sum[FW]);
      w_phase_wrap = (r_phase == OSW'(OSR - 1));
      if (!i_ch_en) begin
         w_mode = CH_OFF;
      end else if (i_sync) begin
         w_mode = CH_SYNC;
      end else if (r_cnt == w_last) begin
         w_mode = CH_TICK;
      end else begin
         w_mode = CH_RUN;
      end
   end

   // Next-state for counter, accumulator, phase, divisors and ticks
   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_acc_nxt      = r_acc;
      w_phase_nxt    = r_phase;
      w_int_act_nxt  = r_int_act;
      w_frac_act_nxt = r_frac_act;
      w_int_sh_nxt   = r_int_sh;
      w_frac_sh_nxt  = r_frac_sh;
      w_pend_nxt     = r_pend;
      w_os_nxt       = 1'b0;
      w_bit_nxt      = 1'b0;
      case (w_mode)
         CH_OFF, CH_SYNC: begin
            // restart: new or pending divisor becomes active at once
            w_cnt_nxt   = {DW{1'b0}};
            w_acc_nxt   = {FW{1'b0}};
            w_phase_nxt = (w_mode == CH_SYNC) ? OSW'(OSR / 2) : {OSW{1'b0}};
            w_pend_nxt  = 1'b0;
            if (i_cfg_upd) begin
               w_int_act_nxt  = i_div_int;
               w_frac_act_nxt = i_div_frac;
               w_int_sh_nxt   = i_div_int;
               w_frac_sh_nxt  = i_div_frac;
            end else if (r_pend) begin
               w_int_act_nxt  = r_int_sh;
               w_frac_act_nxt = r_frac_sh;
            end else begin
               w_int_act_nxt  = r_int_act;
            end
         end
         CH_TICK: begin
            w_cnt_nxt   = {DW{1'b0}};
            w_acc_nxt   = w_sum[FW-1:0];
            w_phase_nxt = w_phase_wrap ? {OSW{1'b0}} : r_phase + OSW'(1'b1);
            w_os_nxt    = 1'b1;
            w_bit_nxt   = w_phase_wrap;
            // period boundary: the only point where a shadow may go live
            if (r_pend) begin
               w_int_act_nxt  = r_int_sh;
               w_frac_act_nxt = r_frac_sh;
               w_pend_nxt     = 1'b0;
            end else begin
               w_pend_nxt     = r_pend;
            end
            if (i_cfg_upd) begin
               w_int_sh_nxt  = i_div_int;
               w_frac_sh_nxt = i_div_frac;
               w_pend_nxt    = 1'b1;
            end else begin
               w_int_sh_nxt  = r_int_sh;
            end
         end
         default: begin
            w_cnt_nxt = r_cnt + DW'(1'b1);
            if (i_cfg_upd) begin
               w_int_sh_nxt  = i_div_int;
               w_frac_sh_nxt = i_div_frac;
               w_pend_nxt    = 1'b1;
            end else begin
               w_int_sh_nxt  = r_int_sh;
            end
         end
      endcase
   end

   // Channel state registers
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_cnt      <= {DW{1'b0}};
         r_acc      <= {FW{1'b0}};
         r_phase    <= {OSW{1'b0}};
         r_int_act  <= {DW{1'b0}};
         r_frac_act <= {FW{1'b0}};
         r_int_sh   <= {DW{1'b0}};
         r_frac_sh  <= {FW{1'b0}};
         r_pend     <= 1'b0;
         r_os_tick  <= 1'b0;
         r_bit_tick <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_acc      <= w_acc_nxt;
         r_phase    <= w_phase_nxt;
         r_int_act  <= w_int_act_nxt;
         r_frac_act <= w_frac_act_nxt;
         r_int_sh   <= w_int_sh_nxt;
         r_frac_sh  <= w_frac_sh_nxt;
         r_pend     <= w_pend_nxt;
         r_os_tick  <= w_os_nxt;
         r_bit_tick <= w_bit_nxt;
      end
   end

   assign o_cfg_pend = r_pend;
   assign o_os_tick  = r_os_tick;
   assign o_bit_tick = r_bit_tick;
   assign o_os_phase = r_phase;

endmodule

// File: rtl/cb_baud_gen_mc.sv
// -----------------------------------------------------------------------------
// cb_baud_gen_mc
// Multi-channel fractional baud generator: NCH independent cb_baud_ch
// instances; this level only slices the packed vectors of the bus.
//   clk_sys : system clock
//   rst     : async reset, active-high
//   bus     : cb_baud_gen_mc_if slave (enables, divisors, sync, ticks, phase)
// -----------------------------------------------------------------------------
module cb_baud_gen_mc
   import cb_baud_pkg::*;
#(
   parameter int unsigned NCH = 2,
   parameter int unsigned DW  = 16,
   parameter int unsigned FW  = 4,
   parameter int unsigned OSR = 16
) (
   input  logic            clk_sys,
   input  logic            rst,
   cb_baud_gen_mc_if.slave bus
);

   localparam int unsigned OSW = phase_width(OSR);

   genvar k;
   generate
      for (k = 0; k < NCH; k++) begin : g_ch
         cb_baud_ch #(
            .DW  (DW),
            .FW  (FW),
            .OSR (OSR),
            .OSW (OSW)
         ) u_ch (
            .clk_sys    (clk_sys),
            .rst        (rst),
            .i_ch_en    (bus.ch_en[k]),
            .i_cfg_upd  (bus.cfg_upd[k]),
            .i_sync     (bus.sync[k]),
            .i_div_int  (bus.div_int[k*DW +: DW]),
            .i_div_frac (bus.div_frac[k*FW +: FW]),
            .o_cfg_pend (bus.cfg_pend[k]),
            .o_os_tick  (bus.os_tick[k]),
            .o_bit_tick (bus.bit_tick[k]),
            .o_os_phase (bus.os_phase[k*OSW +: OSW])
         );
      end
   endgenerate

endmodule
